// File: rtl/defuzz_seq.sv
// Handshaked defuzzifier: G = round_half_up(S_wg * OUT_MAX / max(S_w, EPS)), capped at OUT_MAX.
// The quotient comes from a restoring divider that produces one bit per clock.
module defuzz_seq #(
    parameter int unsigned W       = 16,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned OUT_MAX = 100,
    parameter int unsigned EPS     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     S_w,
    input  logic [W-1:0]     S_wg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] G_out,
    output logic             eps_hit,
    output logic             sat
);
    localparam int unsigned RW = W + 2;
    localparam int unsigned DW = RW + 1;
    localparam int unsigned NW = W + OUT_W + 2;
    localparam int unsigned CW = $clog2(OUT_W + 1);

    if ((OUT_MAX >> OUT_W) != 0) begin : g_bad_out_max
        $error("defuzz_seq: OUT_MAX must be below 2**OUT_W");
    end
    if (EPS < 1 || (EPS >> W) != 0) begin : g_bad_eps
        $error("defuzz_seq: EPS must satisfy 1 <= EPS < 2**W");
    end

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     den_q, den_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [OUT_W-1:0] nlo_q, nlo_d;
    logic [OUT_W-1:0] quo_q, quo_d;
    logic             eps_r_q, eps_r_d;
    logic [OUT_W-1:0] g_q, g_d;
    logic             eps_hit_q, eps_hit_d;
    logic             sat_q, sat_d;

    logic             in_eps;
    logic [W-1:0]     in_den;
    logic [NW-1:0]    in_n;

    // Rounded numerator N = 2*num*OUT_MAX + den; its top RW bits seed the remainder.
    assign in_eps = S_w < W'(EPS);
    assign in_den = in_eps ? W'(EPS) : S_w;
    assign in_n   = ((NW'(S_wg) * NW'(OUT_MAX)) << 1) + NW'(in_den);

    logic [DW-1:0]    partial;
    logic [DW-1:0]    dvs;
    logic             ge;
    logic [RW-1:0]    step_rem;
    logic [OUT_W-1:0] step_quo;

    assign partial  = {rem_q, nlo_q[OUT_W-1]};
    assign dvs      = DW'({den_q, 1'b0});
    assign ge       = partial >= dvs;
    assign step_rem = ge ? RW'(partial - dvs) : partial[RW-1:0];
    assign step_quo = (quo_q << 1) | OUT_W'(ge);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        den_d     = den_q;
        rem_d     = rem_q;
        nlo_d     = nlo_q;
        quo_d     = quo_q;
        eps_r_d   = eps_r_q;
        g_d       = g_q;
        eps_hit_d = eps_hit_q;
        sat_d     = sat_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    den_d   = in_den;
                    eps_r_d = in_eps;
                    if (S_wg >= in_den) begin
                        state_d   = StDone;
                        g_d       = OUT_W'(OUT_MAX);
                        eps_hit_d = in_eps;
                        sat_d     = 1'b1;
                    end else begin
                        state_d = StDiv;
                        cnt_d   = '0;
                        quo_d   = '0;
                        rem_d   = in_n[NW-1:OUT_W];
                        nlo_d   = in_n[OUT_W-1:0];
                    end
                end
            end
            StDiv: begin
                rem_d = step_rem;
                nlo_d = nlo_q << 1;
                quo_d = step_quo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(OUT_W - 1)) begin
                    state_d   = StDone;
                    g_d       = step_quo;
                    eps_hit_d = eps_r_q;
                    sat_d     = 1'b0;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            den_q     <= '0;
            rem_q     <= '0;
            nlo_q     <= '0;
            quo_q     <= '0;
            eps_r_q   <= 1'b0;
            g_q       <= '0;
            eps_hit_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            den_q     <= den_d;
            rem_q     <= rem_d;
            nlo_q     <= nlo_d;
            quo_q     <= quo_d;
            eps_r_q   <= eps_r_d;
            g_q       <= g_d;
            eps_hit_q <= eps_hit_d;
            sat_q     <= sat_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign G_out     = g_q;
    assign eps_hit   = eps_hit_q;
    assign sat       = sat_q;

endmodule

// File: doc/defuzz_seq.md
Name: defuzz_seq

Overview:
- Parametrised, handshaked successor to the combinational-divide defuzzifier.
- Computes G = round_half_up(S_wg * OUT_MAX / max(S_w, EPS)), saturated to OUT_MAX, with an iterative restoring divider (one quotient bit per clock) instead of a single-cycle divide.
- Sits between the rule-aggregation stage (which produces S_w and S_wg) and the actuator/output register stage.
- Valid/ready on both sides, so upstream and downstream can stall.

Parameters:
- W, 16: width of S_w and S_wg, unsigned Q1.(W-1).
- OUT_W, 8: width of G_out and number of divider iterations.
- OUT_MAX, 100: full-scale output value. Must satisfy OUT_MAX < 2**OUT_W (elaboration assertion).
- EPS, 1: minimum denominator in LSBs. Must satisfy 1 <= EPS < 2**W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  S_w/S_wg valid.
- in_ready  out  1  block can accept; combinational, = (state==IDLE).
- S_w  in  W  sum of rule weights, Q1.(W-1).
- S_wg  in  W  sum of weight*singleton, Q1.(W-1).
- out_valid  out  1  G_out/eps_hit valid.
- out_ready  in  1  downstream accepts.
- G_out  out  OUT_W  result, 0..OUT_MAX.
- eps_hit  out  1  S_w < EPS was clamped for this result.
- sat  out  1  result was saturated (S_wg >= den).

Behaviour:
- Reset values: state=IDLE, out_valid=0, G_out=0, eps_hit=0, sat=0, internal regs=0. in_ready reads 1 during and after reset.
- Accept: handshake occurs on the rising edge where in_valid && in_ready. On that edge, register den = (S_w < EPS) ? EPS : S_w, eps_hit_r = (S_w < EPS), and num = S_wg.
- Inputs are ignored when in_ready=0. No internal input buffering.
- States:
  - IDLE: on accept, go to DONE if num >= den (saturation path), else go to DIV with cnt=0.
  - DIV: one restoring-division step per clock on the rounded numerator N = 2*num*OUT_MAX + den, divisor D = 2*den. Exactly OUT_W iterations; then go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Arithmetic:
  - Result = floor(N/D), i.e. round half up of num*OUT_MAX/den.
  - When num < den the quotient is guaranteed <= OUT_MAX < 2**OUT_W, so no overflow.
  - Remainder/partial registers sized so that no intermediate truncates: at least W+2 bits for the remainder, W+OUT_W+2 bits for N.
  - No double rounding: there is no intermediate Q-format ratio.
- Saturation path: G_out=OUT_MAX, sat=1.
- Latency from the accept edge to out_valid high:
  - Saturation path: 1 clock.
  - Divide path: OUT_W+1 clocks (9 at default).
- G_out, eps_hit and sat are loaded on the edge entering DONE. They hold stable while out_valid && !out_ready.
- After out_valid drops, G_out/eps_hit/sat keep their last value until the next DONE.
- Throughput: a new accept is possible the clock after the output handshake (in_ready is high in IDLE only).
- Boundaries:
  - S_w=0, S_wg=0: den=EPS, eps_hit=1, num<den, G=0 via DIV.
  - S_w=0, S_wg>0: eps_hit=1, sat=1, G=OUT_MAX.
  - S_wg=S_w: saturation path, G=OUT_MAX.
- Reset asserted mid-DIV or in DONE: immediately IDLE, out_valid=0, G_out=0, eps_hit=0, sat=0. The in-flight result is discarded and never presented.
- out_ready high in IDLE/DIV has no effect.

Test Plan:
- S_w=0x4000, S_wg=0x2000 -> G_out=50, sat=0, eps_hit=0; out_valid high exactly 9 clocks after accept; in_ready=0 during those 9 clocks.
- Rounding (S_w, S_wg): (3,1) -> 33; (3,2) -> 67; (8,1) -> 13 (half up); (200,1) -> 1; (201,1) -> 0.
- S_w=0x4000, S_wg=0x5000 -> G_out=100, sat=1, out_valid 1 clock after accept. S_w=0, S_wg=0 -> G_out=0, eps_hit=1. S_w=0, S_wg=5 -> G_out=100, eps_hit=1, sat=1.
- Backpressure: hold out_ready=0 for 5 clocks with in_valid=1 and changing inputs -> G_out/sat/eps_hit stable, in_ready=0, no accept. Raise out_ready -> handshake, IDLE next clock, next operand accepted.
- Pulse rst_n low during DIV cycle 4 -> out_valid=0, G_out=0 immediately. After release, no stale result appears; a fresh S_w=0x7FFF, S_wg=0x7FFF -> 100.
- Randomised 10k operands against a reference model round_half_up(S_wg*OUT_MAX/max(S_w,EPS)) capped at OUT_MAX, with random out_ready. Repeat with W=12, OUT_W=10, OUT_MAX=1000.
